digit_scan_mux: RTL and testbench
=================================

// Module: digit_scan_mux
// PURPOSE
//  Parametrised, time-multiplexed BCD driver for a common-anode 7-segment display.
//  Scans NUM_DIGITS digits one at a time and drives active-low segment lines.
//  Adds leading-zero blanking, per-digit decimal points, invalid-code blanking and a display enable.
//  Sits between the counter/score logic (packed BCD source) and the board segment/select pins.
// PARAMETERS
//  NUM_DIGITS   3      digits scanned; legal range 2..8
//  TICK_CYCLES  50000  clk cycles each digit is shown (1 ms at 50 MHz); must be >= 2
//  BLINK_FRAMES 250    full scan frames per blink half-period (only with DIGIT_BLINK_EN)
// PORTS
//  clk       in   1               system clock, 50 MHz
//  reset     in   1               asynchronous reset, active-high
//  en        in   1               1 = display on, 0 = all digits off
//  lzb       in   1               1 = blank leading zeros
//  bcd       in   4*NUM_DIGITS    packed BCD; bcd[3:0] = digit 0 (least significant)
//  dp        in   NUM_DIGITS      decimal point per digit, 1 = lit
//  blink     in   NUM_DIGITS      per-digit blink request (present only with DIGIT_BLINK_EN)
//  segsig    out  8               segments, active-low; [7] = dp, [6:0] = g..a
//  bitsig    out  NUM_DIGITS      digit select, one-cold; bit i selects digit i
//  digit_idx out  max(1,clog2(N)) index of the digit currently driven
// BEHAVIOUR
//  - All outputs registered. Reset values: segsig = 8'hFF, bitsig = all 1s, digit_idx = 0.
//    Internal tick counter = 0, blink phase = on.
//  - Tick counter runs 0..TICK_CYCLES-1 and then wraps. On the wrap cycle (tick):
//    idx_next = (idx == NUM_DIGITS-1) ? 0 : idx+1.
//  - First tick after reset release lands TICK_CYCLES cycles later and selects digit 0.
//  - On each tick, update digit_idx, bitsig (only bit idx_next = 0) and segsig in the same edge.
//    segsig is decoded from bcd/dp sampled on that cycle. Between ticks, outputs hold.
//  - Decode (value -> segsig[6:0]):
//      0:40  1:79  2:24  3:30  4:19  5:12  6:02  7:78  8:00  9:10
//    Codes 10..15 -> 7F (blank).
//    segsig[7] = ~dp[idx_next]; dp is shown even on a blanked digit.
//  - Leading-zero blanking: when lzb = 1, digit i > 0 is blanked (7F) if it and every higher
//    digit equal 0. Digit 0 is never blanked, so all-zero input shows a single "0".
//  - bcd change latency: visible at that digit's next select, worst case
//    NUM_DIGITS*TICK_CYCLES cycles. No tearing: segsig and bitsig always change together.
//  - en = 0: on the next edge segsig = FF, bitsig = all 1s, tick counter and idx = 0, no scan.
//    en 0->1: scan restarts as after reset.
//  - Reset asserted mid-scan: outputs go to reset values immediately (async).
//    After release, scanning restarts from digit 0.
//  - Counter width = clog2(TICK_CYCLES). No overflow path exists.
// CONFIGURATION
//  - DIGIT_BLINK_EN defined:
//    - Adds the blink port and a frame counter that increments when idx wraps
//      NUM_DIGITS-1 -> 0. Blink phase toggles every BLINK_FRAMES frames.
//    - During the off phase, digits with blink[i] = 1 drive segsig = FF (dp included).
//      bitsig still scans normally.
//    - The frame counter and phase reset on reset or en = 0.
//  - DIGIT_BLINK_EN undefined: no blink port, no frame counter; digits are never blink-blanked.
// TESTING  (NUM_DIGITS=3, TICK_CYCLES=4, BLINK_FRAMES=2)
//  1. Reset held 10 cycles, en=1 -> segsig FF, bitsig 111.
//     Release -> 4th edge gives bitsig 110, digit_idx 0.
//  2. bcd=12'h905, dp=0, lzb=0 -> per 4-cycle slot: (110,92) (101,C0) (011,90), then (110,92) again.
//  3. lzb=1, bcd=12'h007 -> (110,F8) (101,FF) (011,FF).
//     bcd=12'h000 -> (110,C0) (101,FF) (011,FF).
//     bcd=12'h070 -> digit 2 FF, digit 1 F8, digit 0 C0.
//  4. bcd=12'h0A3, dp=3'b010 -> digit 0 B0, digit 1 7F (invalid, dp lit), digit 2 C0.
//  5. Reset pulsed while digit 1 shown -> same-cycle FF/111.
//     After release the first select is digit 0, after 4 cycles. Repeat with en=0 -> FF/111 next edge.
//  6. DIGIT_BLINK_EN, blink=3'b100, bcd=12'h123 -> digit 2 shows F9 for 2 frames, FF for 2 frames,
//     repeating. Digits 0 and 1 are never blanked.

Source files
------------

// File: rtl/digit_scan_mux_if.sv
// Bundle between the packed-BCD source and the 7-segment scan driver.
// The blink request lane exists only when DIGIT_BLINK_EN is defined.
interface digit_scan_mux_if #(
    parameter int NUM_DIGITS = 3
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                    en;
    logic                    lzb;
    logic [4*NUM_DIGITS-1:0] bcd;
    logic [NUM_DIGITS-1:0]   dp;
`ifdef DIGIT_BLINK_EN
    logic [NUM_DIGITS-1:0]   blink;
`endif
    logic [7:0]              segsig;
    logic [NUM_DIGITS-1:0]   bitsig;
    logic [IDX_W-1:0]        digit_idx;

`ifdef DIGIT_BLINK_EN
    modport master (output en, lzb, bcd, dp, blink, input segsig, bitsig, digit_idx);
    modport slave  (input en, lzb, bcd, dp, blink, output segsig, bitsig, digit_idx);
`else
    modport master (output en, lzb, bcd, dp, input segsig, bitsig, digit_idx);
    modport slave  (input en, lzb, bcd, dp, output segsig, bitsig, digit_idx);
`endif
endinterface

// File: rtl/digit_scan_mux.sv
// Time-multiplexed BCD driver for a common-anode 7-segment display (active-low outputs).
// Per-digit blinking is compiled in when DIGIT_BLINK_EN is defined.
module digit_scan_mux #(
    parameter int NUM_DIGITS   = 3,
    parameter int TICK_CYCLES  = 50000
`ifdef DIGIT_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 250
`endif
) (
    input  logic            clk,
    input  logic            reset,
    digit_scan_mux_if.slave bus
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(TICK_CYCLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TICK_CYCLES - 1);

    logic [CNT_W-1:0]      tick_cnt;
    logic                  tick;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      idx_next;
    logic                  live;
    logic [7:0]            seg_q;
    logic [7:0]            seg_next;
    logic [NUM_DIGITS-1:0] bit_q;
    logic [NUM_DIGITS-1:0] bit_next;
    logic [3:0]            digit_val;
    logic                  dp_bit;
    logic                  higher_nz;
    logic                  lz_blank;
    logic [6:0]            glyph;
    logic                  blink_off;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // live stays low until the first tick, so that tick selects digit 0 instead of advancing
    always_comb begin
        tick = (tick_cnt == LAST_CNT);
        if (!live || idx == LAST_IDX)
            idx_next = '0;
        else
            idx_next = idx + 1'b1;
    end

`ifdef DIGIT_BLINK_EN
    localparam int FR_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FR_W-1:0] LAST_FRAME = FR_W'(BLINK_FRAMES - 1);

    logic [FR_W-1:0] frame_cnt;
    logic [FR_W-1:0] frame_next;
    logic            phase_on;
    logic            phase_next;
    logic            blink_bit;

    // A frame ends when the scan wraps from the last digit back to digit 0
    always_comb begin
        frame_next = frame_cnt;
        phase_next = phase_on;
        if (tick && live && idx == LAST_IDX) begin
            if (frame_cnt == LAST_FRAME) begin
                frame_next = '0;
                phase_next = ~phase_on;
            end else begin
                frame_next = frame_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt <= '0;
            phase_on  <= 1'b1;
        end else if (!bus.en) begin
            frame_cnt <= '0;
            phase_on  <= 1'b1;
        end else begin
            frame_cnt <= frame_next;
            phase_on  <= phase_next;
        end
    end

    always_comb begin
        blink_bit = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (IDX_W'(i) == idx_next)
                blink_bit = bus.blink[i];
        end
    end

    // Uses the phase of the frame being entered so digit 0 of a new frame is already correct
    assign blink_off = !phase_next && blink_bit;
`else
    assign blink_off = 1'b0;
`endif

    // A digit counts as a leading zero only if it and every digit above it hold code 0
    always_comb begin
        digit_val = 4'h0;
        dp_bit    = 1'b0;
        higher_nz = 1'b0;
        bit_next  = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (IDX_W'(i) == idx_next) begin
                digit_val   = bus.bcd[4*i +: 4];
                dp_bit      = bus.dp[i];
                bit_next[i] = 1'b0;
            end
            if (IDX_W'(i) >= idx_next && bus.bcd[4*i +: 4] != 4'h0)
                higher_nz = 1'b1;
        end
        lz_blank = bus.lzb && (idx_next != '0) && !higher_nz;
        glyph    = lz_blank ? 7'h7F : decode(digit_val);
        seg_next = blink_off ? 8'hFF : {~dp_bit, glyph};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
            idx      <= '0;
            live     <= 1'b0;
            seg_q    <= 8'hFF;
            bit_q    <= '1;
        end else if (!bus.en) begin
            tick_cnt <= '0;
            idx      <= '0;
            live     <= 1'b0;
            seg_q    <= 8'hFF;
            bit_q    <= '1;
        end else if (tick) begin
            tick_cnt <= '0;
            idx      <= idx_next;
            live     <= 1'b1;
            seg_q    <= seg_next;
            bit_q    <= bit_next;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign bus.segsig    = seg_q;
    assign bus.bitsig    = bit_q;
    assign bus.digit_idx = idx;
endmodule

// File: tb/tb_digit_scan_mux.sv
// Directed bench for digit_scan_mux with NUM_DIGITS=3, TICK_CYCLES=4 (BLINK_FRAMES=2 with DIGIT_BLINK_EN).
module tb_digit_scan_mux;
    localparam int N    = 3;
    localparam int TICK = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    digit_scan_mux_if #(.NUM_DIGITS(N)) bus ();

`ifdef DIGIT_BLINK_EN
    digit_scan_mux #(.NUM_DIGITS(N), .TICK_CYCLES(TICK), .BLINK_FRAMES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
`else
    digit_scan_mux #(.NUM_DIGITS(N), .TICK_CYCLES(TICK)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
`endif

    typedef struct {
        logic            lzb;
        logic [11:0]     bcd;
        logic [2:0]      dp;
        logic [2:0][7:0] seg;
    } vec_t;

    vec_t vecs[10];
    int   checks   = 0;
    int   failures = 0;

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic checkBlank(input string name);
        checkOutput($sformatf("%s seg", name), bus.segsig, 8'hFF);
        checkOutput($sformatf("%s bit", name), {5'b0, bus.bitsig}, 8'h07);
        checkOutput($sformatf("%s idx", name), {6'b0, bus.digit_idx}, 8'h00);
    endtask

    task automatic checkSlot(input string name, input int d, input logic [7:0] seg);
        logic [2:0] eb;
        eb = ~(3'b001 << d);
        checkOutput($sformatf("%s seg", name), bus.segsig, seg);
        checkOutput($sformatf("%s bit", name), {5'b0, bus.bitsig}, {5'b0, eb});
        checkOutput($sformatf("%s idx", name), {6'b0, bus.digit_idx}, 8'(d));
    endtask

    task automatic nextSlot();
        repeat (TICK) @(posedge clk);
        @(negedge clk);
    endtask

    // Loads inputs with the display off for one edge, checks the blanked state, then re-enables
    task automatic applyStimulus(input logic lzb, input logic [11:0] bcd, input logic [2:0] dp, input string name);
        bus.en  = 1'b0;
        bus.lzb = lzb;
        bus.bcd = bcd;
        bus.dp  = dp;
`ifdef DIGIT_BLINK_EN
        bus.blink = 3'b000;
`endif
        @(posedge clk);
        @(negedge clk);
        checkBlank($sformatf("%s off", name));
        bus.en = 1'b1;
    endtask

    initial begin
        vecs[0] = '{1'b0, 12'h905, 3'b000, {8'h90, 8'hC0, 8'h92}};
        vecs[1] = '{1'b1, 12'h007, 3'b000, {8'hFF, 8'hFF, 8'hF8}};
        vecs[2] = '{1'b1, 12'h000, 3'b000, {8'hFF, 8'hFF, 8'hC0}};
        vecs[3] = '{1'b1, 12'h070, 3'b000, {8'hFF, 8'hF8, 8'hC0}};
        vecs[4] = '{1'b0, 12'h0A3, 3'b010, {8'hC0, 8'h7F, 8'hB0}};
        vecs[5] = '{1'b0, 12'h0F8, 3'b111, {8'h40, 8'h7F, 8'h00}};
        vecs[6] = '{1'b1, 12'h0B0, 3'b100, {8'h7F, 8'hFF, 8'hC0}};
        vecs[7] = '{1'b1, 12'h600, 3'b000, {8'h82, 8'hC0, 8'hC0}};
        vecs[8] = '{1'b0, 12'h000, 3'b000, {8'hC0, 8'hC0, 8'hC0}};
        vecs[9] = '{1'b0, 12'h421, 3'b001, {8'h99, 8'hA4, 8'h79}};

        reset   = 1'b1;
        bus.en  = 1'b1;
        bus.lzb = 1'b0;
        bus.bcd = 12'h000;
        bus.dp  = 3'b000;
`ifdef DIGIT_BLINK_EN
        bus.blink = 3'b000;
`endif
        repeat (10) @(posedge clk);
        @(negedge clk);
        checkBlank("reset");
        reset = 1'b0;
        repeat (TICK - 1) @(posedge clk);
        @(negedge clk);
        checkBlank("pre-tick");
        @(posedge clk);
        @(negedge clk);
        checkSlot("first tick", 0, 8'hC0);

        for (int v = 0; v < 10; v++) begin
            applyStimulus(vecs[v].lzb, vecs[v].bcd, vecs[v].dp, $sformatf("v%0d", v));
            for (int s = 0; s < 4; s++) begin
                nextSlot();
                checkSlot($sformatf("v%0d s%0d", v, s), s % 3, vecs[v].seg[s % 3]);
            end
        end

        // bcd changes mid-slot: held until that digit is next selected
        applyStimulus(1'b0, 12'h905, 3'b000, "latency");
        nextSlot();
        checkSlot("latency d0", 0, 8'h92);
        bus.bcd = 12'h123;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkSlot("latency hold", 0, 8'h92);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkSlot("latency d1", 1, 8'hA4);
        nextSlot();
        checkSlot("latency d2", 2, 8'hF9);
        nextSlot();
        checkSlot("latency d0b", 0, 8'hB0);

        // async reset while digit 1 is shown
        nextSlot();
        checkSlot("pre-reset d1", 1, 8'hA4);
        #2 reset = 1'b1;
        #1 checkBlank("async reset");
        @(negedge clk);
        reset = 1'b0;
        nextSlot();
        checkSlot("post-reset d0", 0, 8'hB0);

        // display disable while digit 1 is shown
        nextSlot();
        checkSlot("pre-en d1", 1, 8'hA4);
        bus.en = 1'b0;
        #1 checkSlot("en hold", 1, 8'hA4);
        @(posedge clk);
        @(negedge clk);
        checkBlank("en off");
        bus.en = 1'b1;
        nextSlot();
        checkSlot("en restart d0", 0, 8'hB0);

`ifdef DIGIT_BLINK_EN
        applyStimulus(1'b0, 12'h123, 3'b000, "blink");
        bus.blink = 3'b100;
        for (int s = 0; s < 18; s++) begin
            logic [7:0] exp_seg;
            nextSlot();
            case (s % 3)
                0:       exp_seg = 8'hB0;
                1:       exp_seg = 8'hA4;
                default: exp_seg = (((s / 3) / 2) % 2 == 0) ? 8'hF9 : 8'hFF;
            endcase
            checkSlot($sformatf("blink s%0d", s), s % 3, exp_seg);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
